quartet_axi_lite_access_controller: RTL and testbench
=====================================================

Name: quartet_axi_lite_access_controller

Overview:
- Sequences host AXI4-Lite register traffic from the Zynq general-purpose master port into the quartet test system's single internal register-access port.
- Buffers the AW, W and AR channels one-deep each and arbitrates round-robin between completed writes and reads.
- Issues one request/acknowledge transaction at a time, with a timeout that converts a missing acknowledge into SLVERR.
- Sits between the AXI interconnect master port and the quartet register/configuration fabric.

Parameters:
- ADDR_WIDTH, 32, width of the AXI and register address.
- DATA_WIDTH, 32, width of the data bus; must be 32.
- TIMEOUT_CYCLES, 255, cycles reg_req may stay high without reg_ack before the access is aborted; range 1..65535.

Ports:
- clock  in  1  positive-edge clock (the same clock as S_AXI_ACLK)
- reset  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake
- reg_req  out  1  access request, level, held until ack or timeout
- reg_we  out  1  1 = write, 0 = read
- reg_addr  out  ADDR_WIDTH  access address (the full AxADDR)
- reg_wdata  out  DATA_WIDTH  write data
- reg_wstrb  out  4  write strobes
- reg_ack  in  1  access complete; may be asserted in the same cycle as reg_req
- reg_rdata  in  DATA_WIDTH  read data, valid with reg_ack
- reg_err  in  1  error flag, valid with reg_ack

Behaviour:
- Reset (synchronous, active-high):
  - The state machine goes to IDLE and the aw_full, w_full and ar_full holding flags clear.
  - Priority pointer is set to READ.
  - Timeout counter clears.
  - BVALID, RVALID, reg_req, reg_we = 0; BRESP, RRESP, RDATA, reg_addr, reg_wdata, reg_wstrb = 0.
  - AWREADY, WREADY and ARREADY are 0 while reset is high.
- Channel capture:
  - AWREADY = !aw_full && !reset; WREADY and ARREADY follow the same rule with their own flags.
  - On VALID && READY, the channel's fields are latched and its flag is set.
  - AW and W are accepted independently, in any order or in the same cycle.
- Arbitration (IDLE only):
  - A write is pending when aw_full && w_full; a read is pending when ar_full.
  - If exactly one is pending, grant it.
  - If both are pending, grant the side named by the priority pointer, then flip the pointer to the other side.
  - Granting clears the consumed holding flags in the same edge, so a new AW/W/AR may be accepted while the access is in flight.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
  - ACCESS: reg_req = 1, with reg_we, reg_addr, reg_wdata and reg_wstrb stable.
  - When reg_ack is sampled high:
    - For a read, latch RDATA = reg_rdata.
    - Set the response to SLVERR (2'b10) if reg_err is 1, otherwise OKAY (2'b00).
    - Drop reg_req and go to RESP.
  - RESP: BVALID (write) or RVALID (read) = 1, held until BREADY or RREADY; then go to IDLE, with arbitration in that same cycle.
- Latency: a write whose AW and W arrive at edge 0 has reg_req high in cycle 1. With a same-cycle ack, BVALID is high in cycle 2. Reads have identical timing.
- Timeout:
  - The counter increments every ACCESS cycle in which reg_ack is 0.
  - When it reaches TIMEOUT_CYCLES, drop reg_req, respond SLVERR (RDATA = 0 for reads) and go to RESP.
  - The counter clears on entering ACCESS.
- reg_ack while reg_req = 0 is ignored.
- WSTRB = 0 is forwarded unchanged; no special case.
- BVALID and RVALID are never high together; exactly one access is outstanding at a time.
- Reset mid-access: reg_req drops on the next edge, no response is issued, and buffered channels are discarded.

Test Plan:
- Single write: AWADDR = 0x10, WDATA = 0xDEADBEEF and WSTRB = 0xF in the same cycle; reg_ack returned the cycle reg_req rises -> reg_req high exactly 1 cycle with reg_we = 1 and the address/data/strobes above, BVALID in cycle 2 with BRESP = 00.
- Split write: W arrives 3 cycles before AW -> no reg_req until AW is accepted; data 0x12345678 is forwarded intact.
- Read with error: ARADDR = 0x20, reg_ack after 4 cycles with reg_rdata = 0xA5A5A5A5 and reg_err = 1 -> RDATA = 0xA5A5A5A5, RRESP = 10; RREADY held low 5 cycles -> RVALID held and RDATA stable throughout.
- Contention: a write and a read pending together, twice in succession -> order read, write, read, write; during each in-flight access, the next AW/W/AR is accepted (READY high).
- Timeout: TIMEOUT_CYCLES = 8 and reg_ack never asserted on a read -> reg_req high exactly 8 cycles, RRESP = 10, RDATA = 0; a late reg_ack afterwards is ignored.
- Reset mid-access: reset for 1 cycle while reg_req = 1 -> all outputs at reset values on the next cycle, no B or R response, and the next write completes normally.

Source files
------------

// File: rtl/quartet_axi_lite_access_controller_if.sv
// AXI4-Lite slave-side bundle for the quartet register access controller.
// The master modport is the host side; the slave modport is the controller.
interface quartet_axi_lite_access_controller_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [2:0]            arprot;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/quartet_axi_lite_access_controller.sv
// Bridges AXI4-Lite host traffic onto the quartet single register port,
// one req/ack access at a time with round-robin write/read arbitration.
module quartet_axi_lite_access_controller #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   quartet_axi_lite_access_controller_if.slave s_axi,
   output logic                  reg_req,
   output logic                  reg_we,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   output logic [3:0]            reg_wstrb,
   input  logic                  reg_ack,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   input  logic                  reg_err
);
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   logic                  aw_full_q, aw_full_d;
   logic                  w_full_q, w_full_d;
   logic                  ar_full_q, ar_full_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                  prio_rd_q, prio_rd_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] rwdata_q, rwdata_d;
   logic [3:0]            rwstrb_q, rwstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic aw_hs, w_hs, ar_hs;
   logic wr_pend, rd_pend;
   logic clr_wr, clr_rd;
   logic [1:0] ack_resp;
   logic unused_prot;

   assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

   assign s_axi.awready = !aw_full_q && !reset;
   assign s_axi.wready  = !w_full_q && !reset;
   assign s_axi.arready = !ar_full_q && !reset;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   assign reg_req   = req_q;
   assign reg_we    = we_q;
   assign reg_addr  = addr_q;
   assign reg_wdata = rwdata_q;
   assign reg_wstrb = rwstrb_q;

   assign aw_hs    = s_axi.awvalid && s_axi.awready;
   assign w_hs     = s_axi.wvalid && s_axi.wready;
   assign ar_hs    = s_axi.arvalid && s_axi.arready;
   assign wr_pend  = aw_full_q && w_full_q;
   assign rd_pend  = ar_full_q;
   assign ack_resp = reg_err ? RESP_SLVERR : RESP_OKAY;

   always_comb begin
      state_d   = state_q;
      prio_rd_d = prio_rd_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      rwdata_d  = rwdata_q;
      rwstrb_d  = rwstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      clr_wr    = 1'b0;
      clr_rd    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (wr_pend || rd_pend) begin
               if (rd_pend && (!wr_pend || prio_rd_q)) begin
                  clr_rd = 1'b1;
                  we_d   = 1'b0;
                  addr_d = araddr_q;
               end else begin
                  clr_wr   = 1'b1;
                  we_d     = 1'b1;
                  addr_d   = awaddr_q;
                  rwdata_d = wdata_q;
                  rwstrb_d = wstrb_q;
               end
               if (wr_pend && rd_pend) prio_rd_d = !prio_rd_q;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // An ack on the last allowed cycle wins over the timeout.
            if (reg_ack) begin
               req_d   = 1'b0;
               state_d = RESP;
               if (we_q) begin
                  bvalid_d = 1'b1;
                  bresp_d  = ack_resp;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = ack_resp;
                  rdata_d  = reg_rdata;
               end
            end else if (cnt_q == TO_LAST) begin
               req_d   = 1'b0;
               state_d = RESP;
               if (we_q) begin
                  bvalid_d = 1'b1;
                  bresp_d  = RESP_SLVERR;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = RESP_SLVERR;
                  rdata_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP: begin
            if (bvalid_q && s_axi.bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
            if (rvalid_q && s_axi.rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      aw_full_d = (aw_full_q && !clr_wr) || aw_hs;
      w_full_d  = (w_full_q && !clr_wr) || w_hs;
      ar_full_d = (ar_full_q && !clr_rd) || ar_hs;
      awaddr_d  = aw_hs ? s_axi.awaddr : awaddr_q;
      wdata_d   = w_hs ? s_axi.wdata : wdata_q;
      wstrb_d   = w_hs ? s_axi.wstrb : wstrb_q;
      araddr_d  = ar_hs ? s_axi.araddr : araddr_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         ar_full_q <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         araddr_q  <= '0;
         prio_rd_q <= 1'b1;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         rwdata_q  <= '0;
         rwstrb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rvalid_q  <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         aw_full_q <= aw_full_d;
         w_full_q  <= w_full_d;
         ar_full_q <= ar_full_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         araddr_q  <= araddr_d;
         prio_rd_q <= prio_rd_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         rwdata_q  <= rwdata_d;
         rwstrb_q  <= rwstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end
endmodule

// File: tb/tb_quartet_axi_lite_access_controller.sv
// Directed bench for the quartet AXI4-Lite access controller:
// vector table for single accesses plus multi-cycle corner sequences.
module tb_quartet_axi_lite_access_controller;
   logic        clock;
   logic        reset;
   logic        reg_req;
   logic        reg_we;
   logic [31:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_wstrb;
   logic        reg_ack;
   logic [31:0] reg_rdata;
   logic        reg_err;

   bit auto_ack;
   bit force_ack;
   int ack_delay;

   int          req_cnt;
   int          last_len;
   bit          grant_q[$];
   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;
   int          b_count;
   int          r_count;
   int          both_cnt;

   int n_cmp;
   int n_bad;

   quartet_axi_lite_access_controller_if #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) axi ();

   quartet_axi_lite_access_controller #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .s_axi(axi),
      .reg_req(reg_req),
      .reg_we(reg_we),
      .reg_addr(reg_addr),
      .reg_wdata(reg_wdata),
      .reg_wstrb(reg_wstrb),
      .reg_ack(reg_ack),
      .reg_rdata(reg_rdata),
      .reg_err(reg_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign reg_ack = force_ack ||
                    (auto_ack && reg_req && (req_cnt >= ack_delay));

   // Register-port responder bookkeeping and response monitor.
   always @(posedge clock) begin
      if (reg_req) begin
         req_cnt <= req_cnt + 1;
         if (req_cnt == 0) begin
            grant_q.push_back(reg_we);
            cap_we    <= reg_we;
            cap_addr  <= reg_addr;
            cap_wdata <= reg_wdata;
            cap_wstrb <= reg_wstrb;
         end
      end else begin
         if (req_cnt != 0) last_len <= req_cnt;
         req_cnt <= 0;
      end
      if (axi.bvalid && axi.bready) b_count <= b_count + 1;
      if (axi.rvalid && axi.rready) r_count <= r_count + 1;
      if (axi.bvalid && axi.rvalid) both_cnt <= both_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          dly;
      bit          err;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      int          exp_len;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send(input bit do_aw, input bit do_w, input bit do_ar,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output bit acc_req);
      int n = 0;
      bit aw_hs, w_hs, ar_hs;
      acc_req     = 1'b0;
      axi.awaddr  = addr;
      axi.araddr  = addr;
      axi.wdata   = data;
      axi.wstrb   = strb;
      axi.awvalid = do_aw;
      axi.wvalid  = do_w;
      axi.arvalid = do_ar;
      while ((axi.awvalid || axi.wvalid || axi.arvalid) && n < 100) begin
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         ar_hs = axi.arvalid && axi.arready;
         if (aw_hs || w_hs || ar_hs) acc_req = reg_req;
         tick();
         n++;
         if (aw_hs) axi.awvalid = 1'b0;
         if (w_hs)  axi.wvalid  = 1'b0;
         if (ar_hs) axi.arvalid = 1'b0;
      end
      if (n >= 100) begin
         chk("accept", 1, 0);
         axi.awvalid = 1'b0;
         axi.wvalid  = 1'b0;
         axi.arvalid = 1'b0;
      end
   endtask

   task automatic wait_valid(input bit wr);
      int n = 0;
      while (!(wr ? axi.bvalid : axi.rvalid) && n < 100) begin
         tick();
         n++;
      end
      chk(wr ? "bvalid_wait" : "rvalid_wait",
          wr ? axi.bvalid : axi.rvalid, 1);
   endtask

   initial begin
      bit          acc, acc1, acc2, seen;
      logic [1:0]  resp;
      logic [31:0] rd;
      int          g0, b0, r0, n;

      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0,
                  2'b00, 32'h0, 1};
      vecs[1] = '{1'b1, 32'h14, 32'h0BADF00D, 4'h0, 2, 1'b0,
                  2'b00, 32'h0, 3};
      vecs[2] = '{1'b0, 32'h20, 32'hA5A5A5A5, 4'h0, 4, 1'b1,
                  2'b10, 32'hA5A5A5A5, 5};
      vecs[3] = '{1'b0, 32'h24, 32'h01234567, 4'h0, 0, 1'b0,
                  2'b00, 32'h01234567, 1};
      vecs[4] = '{1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'h5, 1, 1'b1,
                  2'b10, 32'h0, 2};
      vecs[5] = '{1'b0, 32'h0, 32'h80000001, 4'h0, 7, 1'b0,
                  2'b00, 32'h80000001, 8};

      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      auto_ack = 1'b0;
      force_ack = 1'b0;
      ack_delay = 0;
      reg_rdata = '0;
      reg_err = 1'b0;
      axi.awaddr = '0;
      axi.awprot = '0;
      axi.awvalid = 1'b0;
      axi.wdata = '0;
      axi.wstrb = '0;
      axi.wvalid = 1'b0;
      axi.bready = 1'b1;
      axi.araddr = '0;
      axi.arprot = '0;
      axi.arvalid = 1'b0;
      axi.rready = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_awready", axi.awready, 0);
      chk("rst_wready", axi.wready, 0);
      chk("rst_arready", axi.arready, 0);
      chk("rst_bvalid", axi.bvalid, 0);
      chk("rst_rvalid", axi.rvalid, 0);
      chk("rst_req", reg_req, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_rdata", axi.rdata, 0);
      reset = 1'b0;
      tick();
      chk("post_rst_awready", axi.awready, 1);

      // Single write with exact latency
      auto_ack = 1'b1;
      ack_delay = 0;
      axi.awaddr = 32'h10;
      axi.wdata = 32'hDEADBEEF;
      axi.wstrb = 4'hF;
      axi.awvalid = 1'b1;
      axi.wvalid = 1'b1;
      tick();
      axi.awvalid = 1'b0;
      axi.wvalid = 1'b0;
      chk("lat_c0_req", reg_req, 0);
      tick();
      chk("lat_c1_req", reg_req, 1);
      chk("lat_c1_we", reg_we, 1);
      chk("lat_c1_addr", reg_addr, 32'h10);
      chk("lat_c1_wdata", reg_wdata, 32'hDEADBEEF);
      chk("lat_c1_wstrb", reg_wstrb, 4'hF);
      tick();
      chk("lat_c2_req", reg_req, 0);
      chk("lat_c2_bvalid", axi.bvalid, 1);
      chk("lat_c2_bresp", axi.bresp, 2'b00);
      tick();
      chk("lat_c3_bvalid", axi.bvalid, 0);
      tick();

      // Vector table
      for (int i = 0; i < 6; i++) begin
         ack_delay = vecs[i].dly;
         reg_rdata = vecs[i].data;
         reg_err = vecs[i].err;
         send(vecs[i].wr, vecs[i].wr, !vecs[i].wr, vecs[i].addr,
              vecs[i].data, vecs[i].strb, acc);
         wait_valid(vecs[i].wr);
         resp = vecs[i].wr ? axi.bresp : axi.rresp;
         rd = axi.rdata;
         tick();
         tick();
         chk($sformatf("v%0d_resp", i), resp, vecs[i].exp_resp);
         chk($sformatf("v%0d_we", i), cap_we, vecs[i].wr);
         chk($sformatf("v%0d_addr", i), cap_addr, vecs[i].addr);
         chk($sformatf("v%0d_len", i), last_len, vecs[i].exp_len);
         if (vecs[i].wr) begin
            chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].data);
            chk($sformatf("v%0d_wstrb", i), cap_wstrb, vecs[i].strb);
         end else begin
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         end
      end

      // Split write: W three cycles before AW
      ack_delay = 0;
      reg_err = 1'b0;
      send(1'b0, 1'b1, 1'b0, 32'h0, 32'h12345678, 4'hF, acc);
      seen = 1'b0;
      repeat (3) begin
         seen |= reg_req;
         tick();
      end
      chk("split_no_req", seen, 0);
      send(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'h0, acc);
      wait_valid(1'b1);
      chk("split_bresp", axi.bresp, 2'b00);
      tick();
      tick();
      chk("split_addr", cap_addr, 32'h44);
      chk("split_wdata", cap_wdata, 32'h12345678);

      // Read with error, RREADY held low 5 cycles
      axi.rready = 1'b0;
      ack_delay = 4;
      reg_rdata = 32'hA5A5A5A5;
      reg_err = 1'b1;
      send(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, acc);
      wait_valid(1'b0);
      reg_rdata = 32'h0;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d_rvalid", k), axi.rvalid, 1);
         chk($sformatf("hold%0d_rdata", k), axi.rdata, 32'hA5A5A5A5);
         chk($sformatf("hold%0d_rresp", k), axi.rresp, 2'b10);
         tick();
      end
      axi.rready = 1'b1;
      tick();
      chk("hold_release_rvalid", axi.rvalid, 0);
      reg_err = 1'b0;
      tick();

      // Contention twice in succession
      ack_delay = 1;
      reg_rdata = 32'h11111111;
      g0 = grant_q.size();
      b0 = b_count;
      r0 = r_count;
      send(1'b1, 1'b1, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, acc);
      send(1'b0, 1'b0, 1'b1, 32'h34, 32'h0, 4'h0, acc1);
      send(1'b1, 1'b1, 1'b0, 32'h38, 32'h66778899, 4'h3, acc2);
      chk("cont_ar_inflight", acc1, 1);
      chk("cont_w_inflight", acc2, 1);
      n = 0;
      while ((b_count < b0 + 2 || r_count < r0 + 2) && n < 200) begin
         tick();
         n++;
      end
      chk("cont_done", n < 200, 1);
      tick();
      chk("cont_grants", grant_q.size() - g0, 4);
      if (grant_q.size() >= g0 + 4) begin
         chk("cont_g0", grant_q[g0], 0);
         chk("cont_g1", grant_q[g0 + 1], 1);
         chk("cont_g2", grant_q[g0 + 2], 0);
         chk("cont_g3", grant_q[g0 + 3], 1);
      end

      // Read timeout after 8 cycles, late ack ignored
      auto_ack = 1'b0;
      send(1'b0, 1'b0, 1'b1, 32'h50, 32'h0, 4'h0, acc);
      wait_valid(1'b0);
      chk("to_rresp", axi.rresp, 2'b10);
      chk("to_rdata", axi.rdata, 32'h0);
      tick();
      tick();
      chk("to_len", last_len, 8);
      b0 = b_count;
      r0 = r_count;
      force_ack = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         seen |= reg_req | axi.rvalid | axi.bvalid;
         tick();
      end
      force_ack = 1'b0;
      chk("late_ack_ignored", seen, 0);
      chk("late_ack_no_resp", (b_count - b0) + (r_count - r0), 0);

      // Reset mid-access
      send(1'b1, 1'b1, 1'b0, 32'h60, 32'h77777777, 4'hF, acc);
      n = 0;
      while (!reg_req && n < 20) begin
         tick();
         n++;
      end
      chk("mid_req_seen", reg_req, 1);
      send(1'b0, 1'b0, 1'b1, 32'h68, 32'h0, 4'h0, acc);
      b0 = b_count;
      r0 = r_count;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_req", reg_req, 0);
      chk("mid_we", reg_we, 0);
      chk("mid_addr", reg_addr, 0);
      chk("mid_wdata", reg_wdata, 0);
      chk("mid_wstrb", reg_wstrb, 0);
      chk("mid_bvalid", axi.bvalid, 0);
      chk("mid_rvalid", axi.rvalid, 0);
      seen = 1'b0;
      repeat (5) begin
         seen |= reg_req | axi.bvalid | axi.rvalid;
         tick();
      end
      chk("mid_discarded", seen, 0);
      chk("mid_no_resp", (b_count - b0) + (r_count - r0), 0);
      auto_ack = 1'b1;
      ack_delay = 0;
      send(1'b1, 1'b1, 1'b0, 32'h64, 32'hCAFEF00D, 4'hF, acc);
      wait_valid(1'b1);
      chk("post_bresp", axi.bresp, 2'b00);
      tick();
      tick();
      chk("post_addr", cap_addr, 32'h64);
      chk("post_wdata", cap_wdata, 32'hCAFEF00D);

      chk("b_r_exclusive", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
